// File: rtl/ucdp_clk_mux_ctrl_pkg.sv
// Shared types and constants for the clock mux switch sequencer.
// State codes are plain constants so legacy tooling can read them.
package ucdp_clk_mux_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WAIT_OFF = 3'd1;
    localparam state_t ST_SETTLE   = 3'd2;
    localparam state_t ST_WAIT_ON  = 3'd3;
    localparam state_t ST_ABORT    = 3'd4;

    localparam int TMO_W_DEF = 8;
    localparam int TMO_MAX   = (1 << TMO_W_DEF) - 1;

endpackage

// File: rtl/ucdp_clk_mux_ctrl.sv
// Glitch-free switch sequencer for a 2:1 clock mux behind two clock gates.
// Gates off, flips select, settles, gates back on; bounded waits on acks.
module ucdp_clk_mux_ctrl #(
    parameter int SETTLE_W = 4,
    parameter int TMO_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                sel_req_i,
    input  logic [SETTLE_W-1:0] settle_i,
    input  logic                err_clr_i,
    input  logic                gate_ack_a_i,
    input  logic                gate_ack_b_i,
    output logic                gate_en_a_o,
    output logic                gate_en_b_o,
    output logic                sel_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    import ucdp_clk_mux_ctrl_pkg::*;

    localparam logic [TMO_W-1:0] TMO_LIM = '1;

    state_t              state;
    logic                target;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [SETTLE_W-1:0] settle_cnt;

    logic acks_off;
    logic acks_on;
    logic tmo_hit;

    assign acks_off = !gate_ack_a_i && !gate_ack_b_i;
    assign acks_on  = gate_ack_a_i && gate_ack_b_i;
    assign tmo_hit  = (tmo_cnt == TMO_LIM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            target      <= 1'b0;
            tmo_cnt     <= '0;
            settle_cnt  <= '0;
            sel_o       <= 1'b0;
            gate_en_a_o <= 1'b1;
            gate_en_b_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            // later timeout assignments override this, so a set wins
            if (err_clr_i) begin
                err_o <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        err_o <= 1'b0;
                        if (sel_req_i == sel_o) begin
                            done_o <= 1'b1;
                        end else begin
                            target      <= sel_req_i;
                            gate_en_a_o <= 1'b0;
                            gate_en_b_o <= 1'b0;
                            busy_o      <= 1'b1;
                            tmo_cnt     <= '0;
                            state       <= ST_WAIT_OFF;
                        end
                    end
                end
                ST_WAIT_OFF: begin
                    if (acks_off) begin
                        sel_o      <= target;
                        settle_cnt <= (settle_i == '0) ?
                                      SETTLE_W'(1) : settle_i;
                        state      <= ST_SETTLE;
                    end else if (tmo_hit) begin
                        err_o <= 1'b1;
                        state <= ST_ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 1'b1;
                    if (settle_cnt <= SETTLE_W'(1)) begin
                        gate_en_a_o <= 1'b1;
                        gate_en_b_o <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= ST_WAIT_ON;
                    end
                end
                ST_WAIT_ON: begin
                    if (acks_on) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (tmo_hit) begin
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_ABORT: begin
                    gate_en_a_o <= 1'b1;
                    gate_en_b_o <= 1'b1;
                    done_o      <= 1'b1;
                    busy_o      <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucdp_clk_mux_ctrl.sv
// Bench for ucdp_clk_mux_ctrl: timeline model of each switch request
// with acks derived from the modelled enables, plus directed pins.
module tb_ucdp_clk_mux_ctrl;

    localparam int TMO_MAX_B = 15;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_i = 1'b0;
    logic       sel_req_i = 1'b0;
    logic [3:0] settle_i = 4'd1;
    logic       err_clr_i = 1'b0;
    logic       gate_ack_a_i = 1'b1;
    logic       gate_ack_b_i = 1'b1;
    logic       gate_en_a_o, gate_en_b_o, sel_o, busy_o, done_o, err_o;

    ucdp_clk_mux_ctrl #(.SETTLE_W(4), .TMO_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .sel_req_i(sel_req_i),
        .settle_i(settle_i), .err_clr_i(err_clr_i),
        .gate_ack_a_i(gate_ack_a_i), .gate_ack_b_i(gate_ack_b_i),
        .gate_en_a_o(gate_en_a_o), .gate_en_b_o(gate_en_b_o),
        .sel_o(sel_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;

    // timeline of the current request, in absolute cycle numbers
    int c = -1;
    int t_off = -1, t_on = -1, t_sel = -1, t_done = 0, t_err = -1;
    bit busy_seq = 0, done_pend = 0, sel_tgt = 0;
    bit exp_sel = 0, exp_err = 0, err_nxt = 0;
    bit cur_stuck = 0;
    int cur_d = 0;
    bit en_hist [0:8191];

    bit n_rst = 1, n_req = 0, n_sel = 0, n_clr = 0, n_stuck = 0;
    int n_d = 0;
    logic [3:0] n_settle = 4'd1;

    int last_sel = -1, last_enhi = -1, last_done = -1, last_err = -1;
    int done_cnt = 0;
    bit p_sel = 0, p_en = 1, p_err = 0;
    int t0;

    task automatic lit(string nm, int got, int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s got %0d required %0d", nm, got, want);
    endtask

    task automatic step();
        bit e_en, e_busy, e_done, ah;
        int s;
        @(negedge clk);
        c++;
        if (c == t_sel) exp_sel = sel_tgt;
        exp_err = err_nxt;
        e_en   = !(c >= t_off && c < t_on);
        e_busy = busy_seq && c >= t_off && c < t_done;
        e_done = done_pend && c == t_done;
        en_hist[c] = e_en;
        if (c >= 1) begin
            total++;
            if ({sel_o, gate_en_a_o, gate_en_b_o, busy_o, done_o, err_o} ===
                {exp_sel, e_en, e_en, e_busy, e_done, exp_err})
                passed++;
            else
                $display("FAIL cyc%0d sel/ena/enb/busy/done/err got %b%b%b%b%b%b required %b%b%b%b%b%b",
                         c, sel_o, gate_en_a_o, gate_en_b_o, busy_o, done_o,
                         err_o, exp_sel, e_en, e_en, e_busy, e_done, exp_err);
            if (done_o === 1'b1) begin
                done_cnt++;
                last_done = c;
            end
            if (sel_o !== p_sel) last_sel = c;
            if (gate_en_a_o === 1'b1 && !p_en) last_enhi = c;
            if (err_o === 1'b1 && !p_err) last_err = c;
            p_sel = (sel_o === 1'b1);
            p_en  = (gate_en_a_o === 1'b1);
            p_err = (err_o === 1'b1);
        end
        // gates report their enable state cur_d cycles late
        ah = (c - cur_d >= 0) ? en_hist[c - cur_d] : 1'b1;
        gate_ack_a_i = ah;
        gate_ack_b_i = cur_stuck ? 1'b1 : ah;
        rst_i     = n_rst;
        req_i     = n_req;
        sel_req_i = n_sel;
        settle_i  = n_settle;
        err_clr_i = n_clr;
        if (n_rst) begin
            t_off = -1; t_on = -1; t_err = -1;
            t_sel = c + 1; sel_tgt = 0;
            t_done = c + 1;
            busy_seq = 0; done_pend = 0; cur_stuck = 0;
            err_nxt = 0;
        end else begin
            err_nxt = exp_err;
            if (n_clr) err_nxt = 0;
            if (n_req && c >= t_done) begin
                err_nxt = 0;
                done_pend = 1;
                if (n_sel == exp_sel) begin
                    t_off = c + 1; t_on = c + 1; t_done = c + 1;
                    busy_seq = 0; t_sel = -1;
                end else begin
                    cur_d = n_d; cur_stuck = n_stuck;
                    sel_tgt = n_sel; busy_seq = 1;
                    t_off = c + 1;
                    if (n_stuck) begin
                        t_sel = -1;
                        t_err = c + 2 + TMO_MAX_B;
                        t_on = c + 3 + TMO_MAX_B;
                        t_done = t_on;
                    end else begin
                        s = (n_settle == 0) ? 1 : int'(n_settle);
                        t_err = -1;
                        t_sel = c + 2 + n_d;
                        t_on = t_sel + s;
                        t_done = t_on + n_d + 1;
                    end
                end
            end
            if (c + 1 == t_err) err_nxt = 1;
        end
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_gap();
        int k;
        k = 0;
        while (c + 1 < t_done + 4 && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            total++;
            $display("FAIL wait_gap timed out at cycle %0d", c);
        end
    endtask

    task automatic do_req(bit s, logic [3:0] st, int d, bit stuck);
        wait_gap();
        n_req = 1; n_sel = s; n_settle = st; n_d = d; n_stuck = stuck;
        step();
        t0 = c;
        n_req = 0; n_stuck = 0;
    endtask

    initial begin
        int dc;
        steps(3);
        n_rst = 0;
        steps(5);
        lit("reset_sel", int'(sel_o), 0);
        lit("reset_en_a", int'(gate_en_a_o), 1);
        lit("reset_en_b", int'(gate_en_b_o), 1);
        lit("reset_busy", int'(busy_o), 0);
        lit("reset_err", int'(err_o), 0);

        dc = done_cnt;
        do_req(1, 4'd3, 2, 0);
        steps(14);
        lit("sw1_sel_cycle", last_sel - t0, 4);
        lit("sw1_enhi_cycle", last_enhi - t0, 7);
        lit("sw1_done_cycle", last_done - t0, 10);
        lit("sw1_done_count", done_cnt - dc, 1);

        do_req(1, 4'd3, 2, 0);
        steps(4);
        lit("same_done_cycle", last_done - t0, 1);

        do_req(0, 4'd1, 0, 0);
        steps(6);
        lit("min_sel_cycle", last_sel - t0, 2);
        lit("min_enhi_cycle", last_enhi - t0, 3);
        lit("min_done_cycle", last_done - t0, 4);

        do_req(1, 4'd2, 1, 1);
        steps(20);
        lit("tmo_err_cycle", last_err - t0, 17);
        lit("tmo_done_cycle", last_done - t0, 18);
        lit("tmo_sel_kept", int'(sel_o), 0);
        n_clr = 1;
        step();
        n_clr = 0;
        step();
        lit("err_clr", int'(err_o), 0);

        dc = done_cnt;
        do_req(1, 4'd8, 1, 0);
        steps(3);
        n_rst = 1;
        step();
        n_rst = 0;
        steps(2);
        lit("rst_mid_sel", int'(sel_o), 0);
        lit("rst_mid_no_done", done_cnt - dc, 0);

        dc = done_cnt;
        do_req(1, 4'd0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            n_req = 1;
            n_sel = i[0];
            step();
        end
        n_req = 0;
        steps(10);
        lit("pulse_enhi_cycle", last_enhi - t0, 4);
        lit("pulse_done_count", done_cnt - dc, 1);

        for (int i = 0; i < 1500; i++) begin
            n_clr = ($urandom_range(0, 15) == 0);
            if (c + 1 >= t_done + 4 && $urandom_range(0, 3) == 0) begin
                n_req = 1;
                n_sel = $urandom_range(0, 1);
                n_settle = 4'($urandom_range(0, 15));
                n_d = $urandom_range(0, 3);
                n_stuck = ($urandom_range(0, 9) == 0);
            end else begin
                n_req = (c + 1 < t_done) && ($urandom_range(0, 2) == 0);
                n_sel = $urandom_range(0, 1);
                n_stuck = 0;
            end
            step();
        end
        n_req = 0;
        n_clr = 0;
        steps(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
